// File: rtl/lib_cpu_pkg.sv
// lib_cpu: shared CPU defaults and types (register width, register count, index/word types)
package lib_cpu;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 16;
  typedef logic [3:0] reg_idx_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/gr_file_mp_scoreboard.sv
// gr_scoreboard: per-register busy bits, set by issue (iss_en/iss_rd), cleared by writes (w_en/rd); outputs busy vector and busy_any
module gr_scoreboard
  import lib_cpu::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWR = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    w_en,
  input  logic [NWR*AW-1:0] rd,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREG-1:0]   busy,
  output logic              busy_any
);
  logic [NREG-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NWR; i++) if (w_en[i]) busy_d[rd[i*AW +: AW]] = 1'b0;
    if (iss_en) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy = busy_q;
  assign busy_any = |busy_q;
endmodule

// File: rtl/gr_file_mp.sv
// gr_file_mp: multi-port register file with write bypass and busy scoreboard; in: clk reset w_en rd x_rd rs iss_en iss_rd, out: x_rs rs_busy busy_any
module gr_file_mp
  import lib_cpu::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NWR-1:0]      w_en,
  input  logic [NWR*AW-1:0]   rd,
  input  logic [NWR*XLEN-1:0] x_rd,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] x_rs,
  output logic [NRD-1:0]      rs_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic                busy_any
);
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy;
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NWR; i++) if (w_en[i]) regs_d[rd[i*AW +: AW]] = x_rd[i*XLEN +: XLEN];
    regs_d[0] = '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = rs[j*AW +: AW];
    assign x_rs[j*XLEN +: XLEN] = reset ? '0 : (BYPASS != 0) ? regs_d[idx] : regs_q[idx];
    assign rs_busy[j] = busy[idx];
  end
  gr_scoreboard #(.NREG(NREG), .NWR(NWR)) u_sb (
    .clk(clk),
    .reset(reset),
    .w_en(w_en),
    .rd(rd),
    .iss_en(iss_en),
    .iss_rd(iss_rd),
    .busy(busy),
    .busy_any(busy_any)
  );
endmodule

// File: doc/gr_file_mp.md
Name: gr_file_mp

Overview:
- Parametrised multi-port general-register file with same-cycle write-to-read bypass and a per-register busy scoreboard.
- Next generation of the core's single-write, two-read register file. Sits between decode (read and issue) and writeback (write and busy clear) of the pipelined CPU.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- XLEN, 32, register width in bits.
- NREG, 16, number of registers; power of 2, minimum 2.
- NRD, 2, number of read ports, 1..4.
- NWR, 2, number of write ports, 1..2.
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads return stored state only.
- AW, $clog2(NREG), derived register index width; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- w_en  in  NWR  per-port write enable.
- rd  in  NWR*AW  per-port write index.
- x_rd  in  NWR*XLEN  per-port write data.
- rs  in  NRD*AW  per-port read index.
- x_rs  out  NRD*XLEN  per-port read data, combinational.
- rs_busy  out  NRD  per-port busy flag of the register at rs, combinational.
- iss_en  in  1  issue strobe: mark iss_rd busy.
- iss_rd  in  AW  destination register of the issued instruction.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset (asynchronous assert, synchronous release): all registers become 0 and all busy bits become 0. During reset, x_rs = 0, rs_busy = 0 and busy_any = 0 for any rs.
- Write:
  - On a rising edge with w_en[i]=1 and rd[i]!=0, reg[rd[i]] <= x_rd[i].
  - Writes to index 0 are discarded; reg[0] always reads 0.
- Write collision: if two ports write the same index in one cycle, the higher port index wins (port 1 over port 0). Collisions are legal, not errors.
- Read: x_rs[j] = reg[rs[j]] with zero latency.
- Bypass:
  - With BYPASS=1, if any enabled write port targets rs[j]!=0 this cycle, x_rs[j] returns that port's x_rd. Collision priority applies (the highest port wins).
  - rs[j]=0 always returns 0.
  - With BYPASS=0, reads return the registered value; new data is visible the cycle after the write edge.
- Scoreboard:
  - busy[k] is set on the edge where iss_en=1 and iss_rd=k.
  - busy[k] is cleared on the edge where some w_en[i]=1 and rd[i]=k.
  - Issue and write to the same k in one cycle: set wins, because the new producer supersedes the old one; the write data is still stored.
  - iss_rd=0 is ignored; busy[0] is constant 0.
- rs_busy[j] = busy[rs[j]] as registered; it is not bypassed. With BYPASS=1 the reading stage may treat a matching write as a satisfied hazard. With BYPASS=0 it must stall while rs_busy=1.
- busy_any is registered-state derived and combinational from the busy vector.
- Out-of-range indices cannot occur, since NREG is a power of 2.
- No internal latency beyond one edge for state updates; no handshakes; no stall inputs.

Decomposition:
- Shared package lib_cpu:
  - Add XLEN_DEF=32 and NREG_DEF=16.
  - Add typedef reg_idx_t (logic [3:0]) and word_t (logic [31:0]).
  - The module uses them as parameter defaults.
- Sub-module gr_scoreboard (NREG, NWR):
  - Holds the busy vector with set/clear priority.
  - Outputs the busy vector and busy_any.
- gr_file_mp contains the data array, the write-priority mux and the bypass mux.

Test Plan:
- Reset and zero register:
  - Assert reset mid-run after writing reg5=0xDEADBEEF, then release.
  - Read rs=5 -> 0. rs_busy=0 and busy_any=0.
- Write then read:
  - w_en=01, rd0=3, x_rd0=0x12345678.
  - Next cycle rs0=3 -> 0x12345678.
  - Writing rd=0 with 0xFFFFFFFF leaves rs=0 reading 0.
- Collision:
  - Both ports write rd=7, port0 0xAAAA0000, port1 0x0000BBBB.
  - Next cycle rs=7 -> 0x0000BBBB.
  - With BYPASS=1, the same cycle also reads 0x0000BBBB.
- Bypass modes:
  - BYPASS=1: reg9 holds 0x11, write 0x22 to rd=9, rs=9 same cycle -> 0x22.
  - BYPASS=0: same stimulus -> 0x11 same cycle, 0x22 next cycle.
- Scoreboard:
  - iss_en with iss_rd=4 -> next cycle rs_busy=1 at rs=4 and busy_any=1.
  - Write rd=4 -> next cycle rs_busy=0 and busy_any=0.
  - iss_en with iss_rd=0 -> busy stays 0.
- Issue/write race: busy[6]=1; same cycle iss_en with iss_rd=6 and a write to rd=6 with 0x55 -> next cycle busy[6]=1 and reg6=0x55.
